result_bcd_converter: RTL and testbench
=======================================

// Module: result_bcd_converter
// PURPOSE
//  Converts the signed binary result produced by the calculator ALU into sign + BCD digits for the display path.
//  Sits between the ALU result/ovf outputs and the 7-segment driver.
//  Sequential double-dabble (shift-and-add-3), one bit per clock, with a strobe/busy/done handshake.
//  Flags values the display cannot show.
// PARAMETERS
//  BITS    21  width of signed input result (two's complement)
//  DIGITS  6   number of BCD output digits (4 bits each)
// PORTS
//  clock          in   1           system clock; all state updates on posedge
//  reset_n        in   1           asynchronous, active-low reset
//  result         in   BITS        signed ALU result, sampled on accepted strobe
//  ovf            in   1           ALU overflow flag, sampled with result
//  convertstrobe  in   1           request conversion; accepted only in IDLE
//  busy           out  1           high from accept until done cycle inclusive
//  done           out  1           one-cycle pulse; outputs valid from this cycle
//  sign           out  1           1 = negative value
//  bcd            out  4*DIGITS    digit DIGITS-1 in MSBs; 4'hF = blank code
//  err            out  1           value not displayable (ovf or magnitude > 10^DIGITS-1)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; busy=0, done=0, sign=0, err=0, bcd=0; any conversion is discarded.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: on posedge with convertstrobe=1:
//   - capture sign=result[BITS-1], mag=|result| (BITS-bit unsigned, so -2^(BITS-1) is exact), ovf.
//   - clear the scratch BCD register and bit counter; go to SHIFT; busy=1.
//  SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch,mag} left by 1.
//   - After exactly BITS shifts go to DONE.
//  DONE: update outputs, done=1 for this cycle only, busy=1; next cycle go to IDLE with busy=0.
//   - err=1 if captured ovf=1 or mag > 10^DIGITS-1; then bcd = all 4'hF and sign = captured sign.
//   - otherwise err=0, bcd = scratch.
//  Latency: strobe accepted at edge N -> done high in cycle after edge N+BITS+1 (22 cycles at default).
//  Strobe while busy (SHIFT or DONE) is ignored and not queued.
//   - A strobe in the cycle after done (IDLE again) is accepted.
//  Outputs sign/bcd/err hold their last value between done pulses; they do not change during SHIFT.
//  Scratch register is 4*DIGITS+4 bits so that magnitudes up to 2^BITS-1 never corrupt the err compare.
//  Zero result: sign=0, bcd=0 (subject to optional feature).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - in DONE with err=0, every zero digit above the most significant non-zero digit is replaced by 4'hF.
//   - digit 0 is never blanked.
//  Not defined: all DIGITS digits are output raw, including leading zeros.
//  err=1 output is identical in both builds.
// STRUCTURE
//  Shared header calc_defs.vh holds:
//   - BITS/DIGITS defaults, BCD_BLANK=4'hF, state encodings (IDLE/SHIFT/DONE), MAX_DISPLAY=10^DIGITS-1.
//  One sub-module bcd_add3: combinational 4-bit digit correction (d>=5 ? d+3 : d), instantiated per digit via generate.
//  Counter, FSM and output registers live in result_bcd_converter.
// TESTING
//  result=998001, ovf=0, strobe -> done at cycle 22; sign=0, bcd=24'h998001, err=0; busy high cycles 1..22.
//  result=-1 -> sign=1, err=0; bcd=24'h000001 (no macro) / 24'hFFFFF1 (LEADING_ZERO_BLANK_EN).
//  result=0 -> sign=0; bcd=24'h000000 (no macro) / 24'hFFFFF0 (macro).
//  result=-1048576 -> err=1, sign=1, bcd=24'hFFFFFF.
//  result=1000000 -> err=1, bcd=24'hFFFFFF.
//  result=5 with ovf=1 -> err=1, bcd=24'hFFFFFF.
//  Strobe result=123, then re-strobe result=456 at cycle 5 -> single done; bcd=24'h000123.
//   - Strobe again the cycle after done -> accepted.
//  Strobe result=777; pull reset_n low at cycle 10 -> all outputs 0 immediately, busy=0, no done pulse.
//   - Release reset, strobe -> normal conversion.

Source files
------------

// File: rtl/result_bcd_converter_pkg.sv
// Shared constants for the result-to-BCD converter: default widths, blank code, FSM encodings.
// Optional build macro: LEADING_ZERO_BLANK_EN (see result_bcd_converter.sv).
package result_bcd_converter_pkg;

    localparam int         DEF_BITS   = 21;
    localparam int         DEF_DIGITS = 6;
    localparam logic [3:0] BCD_BLANK  = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: signed ALU result -> sign + BCD digits with err flag.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
//
// state    | meaning
// ST_IDLE  | waiting for convertstrobe; outputs hold last result
// ST_SHIFT | add-3 and shift one magnitude bit per cycle; final cycle registers outputs
// ST_DONE  | outputs valid, done pulse; back to idle next cycle
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BITS-1:0]       result,
    input  logic                  ovf,
    input  logic                  convertstrobe,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  err
);

    // One spare digit above the display width: a non-zero top digit means the value is too large.
    localparam int SW = 4*DIGITS + 4;
    localparam int CW = $clog2(BITS + 1);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_scratch;
    logic [BITS-1:0]     r_mag;
    logic                r_sign_cap;
    logic                r_ovf_cap;
    logic                r_sign;
    logic                r_err;
    logic [4*DIGITS-1:0] r_bcd;

    logic [BITS-1:0]     w_mag;
    logic [SW-1:0]       w_adj;
    logic                w_err;
    logic [4*DIGITS-1:0] w_bcd_out;
    logic                w_unused_adj_msb;

    assign w_mag = result[BITS-1] ? (~result + 1'b1) : result;
    assign w_err = r_ovf_cap | (r_scratch[SW-1 -: 4] != 4'd0);
    assign w_unused_adj_msb = w_adj[SW-1];

    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;

    always_comb begin
        w_bcd_out = r_scratch[4*DIGITS-1:0];
        w_lead    = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (w_lead && (w_bcd_out[4*d +: 4] == 4'd0)) begin
                w_bcd_out[4*d +: 4] = BCD_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_bcd_out = r_scratch[4*DIGITS-1:0];
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_scratch  <= '0;
            r_mag      <= '0;
            r_sign_cap <= 1'b0;
            r_ovf_cap  <= 1'b0;
            r_sign     <= 1'b0;
            r_err      <= 1'b0;
            r_bcd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (convertstrobe) begin
                        r_sign_cap <= result[BITS-1];
                        r_mag      <= w_mag;
                        r_ovf_cap  <= ovf;
                        r_scratch  <= '0;
                        r_cnt      <= CW'(BITS);
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_sign  <= r_sign_cap;
                        r_err   <= w_err;
                        r_bcd   <= w_err ? {DIGITS{BCD_BLANK}} : w_bcd_out;
                        r_state <= ST_DONE;
                    end else begin
                        r_scratch <= {w_adj[SW-2:0], r_mag[BITS-1]};
                        r_mag     <= {r_mag[BITS-2:0], 1'b0};
                        r_cnt     <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign sign = r_sign;
    assign err  = r_err;
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: directed corner cases plus random results vs. an arithmetic model.
module tb_result_bcd_converter;

    logic        clock;
    logic        reset_n;
    logic [20:0] result;
    logic        ovf;
    logic        convertstrobe;
    logic        busy;
    logic        done;
    logic        sign;
    logic [23:0] bcd;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] last_bcd;

    result_bcd_converter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .result        (result),
        .ovf           (ovf),
        .convertstrobe (convertstrobe),
        .busy          (busy),
        .done          (done),
        .sign          (sign),
        .bcd           (bcd),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {sign, err, bcd} from plain decimal arithmetic.
    function automatic logic [25:0] model(input logic [20:0] res, input logic o);
        int          v;
        int          mag;
        int          dg[6];
        logic [23:0] b;
        logic        s;
        logic        e;
        bit          lead;
        v   = $signed(res);
        s   = (v < 0);
        mag = s ? -v : v;
        e   = o || (mag > 999999);
        b   = 24'hFFFFFF;
        if (!e) begin
            for (int i = 0; i < 6; i++) begin
                dg[i] = mag % 10;
                mag   = mag / 10;
            end
`ifdef LEADING_ZERO_BLANK_EN
            lead = 1'b1;
            for (int i = 5; i >= 1; i--) begin
                if (lead && dg[i] == 0) dg[i] = 15;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
            for (int i = 0; i < 6; i++) b[4*i +: 4] = 4'(dg[i]);
        end
        return {s, e, b};
    endfunction

    task automatic start(input logic [20:0] res, input logic o);
        result        = res;
        ovf           = o;
        convertstrobe = 1'b1;
        @(posedge clock); #1;
        convertstrobe = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc, output int busy_low, output bit seen);
        cyc      = from;
        busy_low = 0;
        seen     = 1'b0;
        while (cyc < 60 && !seen) begin
            @(posedge clock); #1;
            cyc++;
            if (!busy) busy_low++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic expect_result(input string tag, input logic [20:0] res, input logic o);
        logic [25:0] m;
        m = model(res, o);
        check({tag, ".sign"}, 32'(sign), 32'(m[25]));
        check({tag, ".err"},  32'(err),  32'(m[24]));
        check({tag, ".bcd"},  32'(bcd),  32'(m[23:0]));
        last_bcd = m[23:0];
    endtask

    task automatic convert_and_check(input string tag, input logic [20:0] res, input logic o);
        int cyc;
        int bl;
        bit seen;
        start(res, o);
        check({tag, ".busy0"}, 32'(busy), 32'd1);
        wait_done(0, cyc, bl, seen);
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'd22);
        check({tag, ".busy_gap"}, 32'(bl), 32'd0);
        expect_result(tag, res, o);
        @(posedge clock); #1;
        check({tag, ".idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          bl;
        bit          seen;
        logic [20:0] r;
        logic        o;

        reset_n       = 1'b0;
        result        = '0;
        ovf           = 1'b0;
        convertstrobe = 1'b0;
        last_bcd      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.out", {7'd0, sign, err, bcd}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        convert_and_check("d998001", 21'd998001, 1'b0);
        convert_and_check("dneg1",   21'h1FFFFF, 1'b0);
        convert_and_check("dzero",   21'd0,      1'b0);
        convert_and_check("dminmax", 21'h100000, 1'b0);
        convert_and_check("d1e6",    21'd1000000, 1'b0);
        convert_and_check("dovf5",   21'd5,      1'b1);
        convert_and_check("d999999", 21'd999999, 1'b0);
        convert_and_check("dneg999999", 21'(-999999), 1'b0);
        convert_and_check("dmaxpos", 21'h0FFFFF, 1'b0);
        convert_and_check("d40500",  21'd40500,  1'b0);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                r = 21'($urandom);
            end else begin
                r = 21'($urandom_range(0, 999999));
                if ($urandom_range(0, 1) == 1) r = -r;
            end
            o = ($urandom_range(0, 7) == 0);
            convert_and_check($sformatf("rnd%0d", k), r, o);
        end

        // Re-strobe while shifting must be ignored; outputs hold during the conversion.
        start(21'd123, 1'b0);
        repeat (4) begin @(posedge clock); #1; end
        result        = 21'd456;
        convertstrobe = 1'b1;
        @(posedge clock); #1;
        convertstrobe = 1'b0;
        check("restrobe.busy", 32'(busy), 32'd1);
        check("restrobe.hold", 32'(bcd), 32'(last_bcd));
        wait_done(5, cyc, bl, seen);
        check("restrobe.done_seen", 32'(seen), 32'd1);
        check("restrobe.latency", 32'(cyc), 32'd22);
        expect_result("restrobe", 21'd123, 1'b0);
        // Strobe during the done cycle is ignored, then accepted once idle.
        result        = 21'd999;
        ovf           = 1'b0;
        convertstrobe = 1'b1;
        @(posedge clock); #1;
        check("done_strobe.ignored", {30'd0, busy, done}, 32'd0);
        @(posedge clock); #1;
        convertstrobe = 1'b0;
        check("after_done.accept", 32'(busy), 32'd1);
        wait_done(0, cyc, bl, seen);
        check("after_done.latency", 32'(cyc), 32'd22);
        expect_result("after_done", 21'd999, 1'b0);
        @(posedge clock); #1;

        // Reset in mid-conversion clears everything immediately.
        start(21'd777, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.out", {7'd0, sign, err, bcd}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrst.quiet", 32'(seen), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        convert_and_check("postrst", 21'd777, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
